// File: rtl/cache_ctrl_nway.sv
// Control unit for an N-way set-associative write-back/write-allocate cache:
// per-set tree PLRU, miss and write-back sequencing, saturating counters.
module cache_ctrl_nway #(
  parameter  int unsigned WAYS  = 4,
  parameter  int unsigned SETS  = 8,
  parameter  int unsigned CNT_W = 32,
  localparam int unsigned WAY_W = $clog2(WAYS),
  localparam int unsigned SET_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [SET_W-1:0] set_idx,
  input  logic [WAYS-1:0]  hit_vec,
  input  logic [WAYS-1:0]  valid_vec,
  input  logic [WAYS-1:0]  dirty_vec,
  input  logic             pmem_resp,
  input  logic             clr_counters,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [WAY_W-1:0] way_sel,
  output logic             pmem_addr_sel,
  output logic             load_line,
  output logic             set_dirty,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);

  localparam int unsigned NODES = WAYS - 1;

  localparam logic [1:0] CHECK      = 2'd0;
  localparam logic [1:0] WRITE_BACK = 2'd1;
  localparam logic [1:0] ALLOCATE   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic             miss_pending_q, miss_pending_d;
  logic [NODES-1:0] plru_q [SETS];
  logic [NODES-1:0] plru_rd, plru_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;

  logic             req, hit;
  logic             hit_inc, miss_inc, wb_inc;
  logic [WAY_W-1:0] hit_way, inv_way, walk_way, victim_c;

  assign req     = mem_read | mem_write;
  assign hit     = |hit_vec;
  assign plru_rd = plru_q[set_idx];

  // Lowest-index hit way; multi-hot vectors resolve to the lowest bit.
  always_comb begin : hit_encode
    hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_way = WAY_W'(i);
    end
  end

  // Lowest-index invalid way, used before the tree once a set is not full.
  always_comb begin : invalid_encode
    inv_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!valid_vec[i]) inv_way = WAY_W'(i);
    end
  end

  // Tree walk: level l node for prefix p is (2^l - 1) + p; bit 1 steers right.
  always_comb begin : plru_walk
    walk_way = '0;
    for (int l = 0; l < int'(WAY_W); l++) begin
      for (int p = 0; p < (1 << l); p++) begin
        if ((walk_way >> (WAY_W - l)) == WAY_W'(p))
          walk_way[WAY_W-1-l] = plru_rd[(1 << l) - 1 + p];
      end
    end
  end

  assign victim_c = (&valid_vec) ? walk_way : inv_way;

  // Point every node on the path to way_sel away from it.
  always_comb begin : plru_next
    plru_d = plru_rd;
    for (int l = 0; l < int'(WAY_W); l++) begin
      for (int p = 0; p < (1 << l); p++) begin
        if ((way_sel >> (WAY_W - l)) == WAY_W'(p))
          plru_d[(1 << l) - 1 + p] = ~way_sel[WAY_W-1-l];
      end
    end
  end

  // Next state and outputs; everything is forced low while reset is high.
  always_comb begin : fsm_comb
    state_d        = state_q;
    victim_d       = victim_q;
    miss_pending_d = miss_pending_q;
    mem_resp       = 1'b0;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    way_sel        = '0;
    pmem_addr_sel  = 1'b0;
    load_line      = 1'b0;
    set_dirty      = 1'b0;
    hit_inc        = 1'b0;
    miss_inc       = 1'b0;
    wb_inc         = 1'b0;
    if (!reset) begin
      unique case (state_q)
        CHECK: begin
          way_sel = hit ? hit_way : victim_c;
          if (req) begin
            if (hit) begin
              mem_resp  = 1'b1;
              set_dirty = mem_write;
            end else begin
              victim_d       = victim_c;
              miss_pending_d = 1'b1;
              miss_inc       = 1'b1;
              state_d        = (valid_vec[victim_c] & dirty_vec[victim_c]) ? WRITE_BACK
                                                                            : ALLOCATE;
            end
          end
        end
        WRITE_BACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          way_sel       = victim_q;
          if (pmem_resp) begin
            wb_inc  = 1'b1;
            state_d = ALLOCATE;
          end
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          way_sel   = victim_q;
          if (pmem_resp) begin
            load_line = 1'b1;
            state_d   = CHECK;
          end
        end
        default: state_d = CHECK;
      endcase
      hit_inc = mem_resp & ~miss_pending_q;
      if (mem_resp) miss_pending_d = 1'b0;
    end
  end

  // Saturating counters; a clear wins over any increment in the same cycle.
  always_comb begin : counter_next
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (clr_counters) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
      wb_cnt_d   = '0;
    end else begin
      if (hit_inc && (hit_cnt_q != CNT_MAX))   hit_cnt_d  = hit_cnt_q + CNT_W'(1);
      if (miss_inc && (miss_cnt_q != CNT_MAX)) miss_cnt_d = miss_cnt_q + CNT_W'(1);
      if (wb_inc && (wb_cnt_q != CNT_MAX))     wb_cnt_d   = wb_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin : state_regs
    if (reset) begin
      state_q        <= CHECK;
      victim_q       <= '0;
      miss_pending_q <= 1'b0;
      hit_cnt_q      <= '0;
      miss_cnt_q     <= '0;
      wb_cnt_q       <= '0;
      for (int s = 0; s < int'(SETS); s++) plru_q[s] <= '0;
    end else begin
      state_q        <= state_d;
      victim_q       <= victim_d;
      miss_pending_q <= miss_pending_d;
      hit_cnt_q      <= hit_cnt_d;
      miss_cnt_q     <= miss_cnt_d;
      wb_cnt_q       <= wb_cnt_d;
      if (mem_resp) plru_q[set_idx] <= plru_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
  assign wb_count   = wb_cnt_q;

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Directed bench for cache_ctrl_nway (4 ways, 8 sets, 4-bit counters so that
// saturation is reachable): hit vector table plus hand-written miss sequences.
module tb_cache_ctrl_nway;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             mem_read, mem_write;
  logic [2:0]       set_idx;
  logic [3:0]       hit_vec, valid_vec, dirty_vec;
  logic             pmem_resp, clr_counters;
  logic             mem_resp, pmem_read, pmem_write;
  logic [1:0]       way_sel;
  logic             pmem_addr_sel, load_line, set_dirty;
  logic [CNT_W-1:0] hit_count, miss_count, wb_count;

  int checks = 0;
  int errors = 0;
  int e_hit  = 0;
  int e_miss = 0;
  int e_wb   = 0;

  cache_ctrl_nway #(.WAYS(4), .SETS(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .set_idx(set_idx), .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec),
    .pmem_resp(pmem_resp), .clr_counters(clr_counters), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .way_sel(way_sel),
    .pmem_addr_sel(pmem_addr_sel), .load_line(load_line), .set_dirty(set_dirty),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sidx;
    logic       rd;
    logic       wr;
    logic [3:0] hit;
    logic       e_resp;
    logic [1:0] e_way;
    logic       e_dirty;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs [NV];

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic idle();
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    hit_vec      = 4'b0000;
    valid_vec    = 4'b1111;
    dirty_vec    = 4'b0000;
    pmem_resp    = 1'b0;
    clr_counters = 1'b0;
  endtask

  task automatic chk_counters(input string nm);
    chkv({nm, " hit_count"},  32'(hit_count),  e_hit);
    chkv({nm, " miss_count"}, 32'(miss_count), e_miss);
    chkv({nm, " wb_count"},   32'(wb_count),   e_wb);
  endtask

  // Single hit cycle on an all-valid set, starting and ending at a falling edge.
  task automatic hit_once(input logic [2:0] s, input int way);
    set_idx  = s;
    mem_read = 1'b1;
    hit_vec  = 4'b0001 << way;
    #1;
    chk1("hit mem_resp", mem_resp, 1'b1);
    chkv("hit way_sel", 32'(way_sel), way);
    @(negedge clk);
    e_hit = sat(e_hit);
    chkv("hit hit_count", 32'(hit_count), e_hit);
    idle();
  endtask

  // Full miss: optional write-back, fill, then the re-check hit on the victim.
  task automatic do_miss(input string nm, input logic [2:0] s, input logic rd, input logic wr,
                         input logic [3:0] valid, input logic [3:0] dirty, input int victim,
                         input logic dirty_path, input int wb_lat, input int fill_lat);
    set_idx   = s;
    mem_read  = rd;
    mem_write = wr;
    hit_vec   = 4'b0000;
    valid_vec = valid;
    dirty_vec = dirty;
    #1;
    chk1({nm, " miss mem_resp"}, mem_resp, 1'b0);
    chk1({nm, " miss pmem_read"}, pmem_read, 1'b0);
    @(negedge clk);
    e_miss = sat(e_miss);
    chkv({nm, " miss_count"}, 32'(miss_count), e_miss);
    if (dirty_path) begin
      chk1({nm, " wb pmem_write"}, pmem_write, 1'b1);
      chk1({nm, " wb pmem_read"}, pmem_read, 1'b0);
      chk1({nm, " wb addr_sel"}, pmem_addr_sel, 1'b1);
      chkv({nm, " wb way_sel"}, 32'(way_sel), victim);
      repeat (wb_lat - 1) @(negedge clk);
      pmem_resp = 1'b1;
      #1;
      chk1({nm, " wb held"}, pmem_write, 1'b1);
      chk1({nm, " wb load_line"}, load_line, 1'b0);
      @(negedge clk);
      pmem_resp = 1'b0;
      e_wb = sat(e_wb);
      chkv({nm, " wb_count"}, 32'(wb_count), e_wb);
    end
    chk1({nm, " fill pmem_read"}, pmem_read, 1'b1);
    chk1({nm, " fill pmem_write"}, pmem_write, 1'b0);
    chk1({nm, " fill addr_sel"}, pmem_addr_sel, 1'b0);
    chkv({nm, " fill way_sel"}, 32'(way_sel), victim);
    repeat (fill_lat - 1) @(negedge clk);
    chk1({nm, " fill held"}, pmem_read, 1'b1);
    pmem_resp = 1'b1;
    #1;
    chk1({nm, " load_line"}, load_line, 1'b1);
    @(negedge clk);
    pmem_resp = 1'b0;
    hit_vec   = 4'b0001 << victim;
    #1;
    chk1({nm, " recheck pmem_read"}, pmem_read, 1'b0);
    chk1({nm, " recheck mem_resp"}, mem_resp, 1'b1);
    chkv({nm, " recheck way_sel"}, 32'(way_sel), victim);
    chk1({nm, " recheck set_dirty"}, set_dirty, wr);
    @(negedge clk);
    chk_counters({nm, " after"});
    idle();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    vecs[0] = '{3'd3, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0};
    vecs[1] = '{3'd3, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0, 1'b1};
    vecs[2] = '{3'd7, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1};
    vecs[3] = '{3'd7, 1'b1, 1'b0, 4'b0110, 1'b1, 2'd1, 1'b0};
    vecs[4] = '{3'd7, 1'b0, 1'b1, 4'b1111, 1'b1, 2'd0, 1'b1};
    vecs[5] = '{3'd3, 1'b0, 1'b0, 4'b0010, 1'b0, 2'd0, 1'b0};
    vecs[6] = '{3'd3, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0};

    // Reset with a write hit presented: every output must stay low.
    idle();
    set_idx   = 3'd0;
    reset     = 1'b1;
    mem_write = 1'b1;
    hit_vec   = 4'b0100;
    repeat (3) @(negedge clk);
    #1;
    chk1("rst mem_resp", mem_resp, 1'b0);
    chk1("rst pmem_read", pmem_read, 1'b0);
    chk1("rst pmem_write", pmem_write, 1'b0);
    chkv("rst way_sel", 32'(way_sel), 0);
    chk1("rst addr_sel", pmem_addr_sel, 1'b0);
    chk1("rst load_line", load_line, 1'b0);
    chk1("rst set_dirty", set_dirty, 1'b0);
    chk_counters("rst");
    idle();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk1("post-rst pmem_read", pmem_read, 1'b0);
    chk1("post-rst pmem_write", pmem_write, 1'b0);
    @(negedge clk);

    // Hit vector table.
    for (int i = 0; i < NV; i++) begin
      set_idx   = vecs[i].sidx;
      mem_read  = vecs[i].rd;
      mem_write = vecs[i].wr;
      hit_vec   = vecs[i].hit;
      #1;
      chk1($sformatf("vec%0d mem_resp", i), mem_resp, vecs[i].e_resp);
      if (vecs[i].e_resp) chkv($sformatf("vec%0d way_sel", i), 32'(way_sel), 32'(vecs[i].e_way));
      chk1($sformatf("vec%0d set_dirty", i), set_dirty, vecs[i].e_dirty);
      chk1($sformatf("vec%0d pmem_read", i), pmem_read, 1'b0);
      @(negedge clk);
      if (vecs[i].e_resp) e_hit = sat(e_hit);
      chkv($sformatf("vec%0d hit_count", i), 32'(hit_count), e_hit);
    end
    idle();

    // Clean miss: way 2 invalid, so its dirty bit is irrelevant.
    do_miss("clean", 3'd1, 1'b0, 1'b1, 4'b1011, 4'b1111, 2, 1'b0, 0, 5);
    // First all-valid miss in a fresh set picks way 0.
    do_miss("fresh", 3'd0, 1'b1, 1'b0, 4'b1111, 4'b0000, 0, 1'b0, 0, 1);
    // Dirty miss through write-back.
    do_miss("dirty", 3'd6, 1'b1, 1'b0, 4'b1111, 4'b0001, 0, 1'b1, 3, 2);

    // PLRU order in set 5: hits 0,2,1,3 leave the tree at 000.
    hit_once(3'd5, 0);
    hit_once(3'd5, 2);
    hit_once(3'd5, 1);
    hit_once(3'd5, 3);
    do_miss("plru1", 3'd5, 1'b1, 1'b0, 4'b1111, 4'b0000, 0, 1'b0, 0, 2);
    // Same order plus a trailing hit on way 0 steers the victim to way 2.
    hit_once(3'd5, 0);
    hit_once(3'd5, 2);
    hit_once(3'd5, 1);
    hit_once(3'd5, 3);
    hit_once(3'd5, 0);
    do_miss("plru2", 3'd5, 1'b1, 1'b0, 4'b1111, 4'b0100, 2, 1'b1, 1, 1);

    // Saturation, then a clear that coincides with a hit.
    for (int i = 0; i < 20; i++) hit_once(3'd7, 1);
    chkv("sat hit_count", 32'(hit_count), 32'(CMAX));
    set_idx      = 3'd7;
    mem_read     = 1'b1;
    hit_vec      = 4'b0010;
    clr_counters = 1'b1;
    @(negedge clk);
    e_hit  = 0;
    e_miss = 0;
    e_wb   = 0;
    chk_counters("clr");
    idle();

    // Reset in the middle of a fill.
    set_idx   = 3'd2;
    mem_read  = 1'b1;
    valid_vec = 4'b0111;
    @(negedge clk);
    e_miss = sat(e_miss);
    chk1("rstmid pmem_read before", pmem_read, 1'b1);
    chkv("rstmid way_sel", 32'(way_sel), 3);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk1("rstmid pmem_read", pmem_read, 1'b0);
    chk1("rstmid pmem_write", pmem_write, 1'b0);
    e_hit  = 0;
    e_miss = 0;
    e_wb   = 0;
    chk_counters("rstmid");
    @(negedge clk);
    idle();
    reset = 1'b0;
    set_idx  = 3'd2;
    mem_read = 1'b1;
    hit_vec  = 4'b0001;
    #1;
    chk1("rstmid check mem_resp", mem_resp, 1'b1);
    chk1("rstmid check pmem_read", pmem_read, 1'b0);
    @(negedge clk);
    e_hit = sat(e_hit);
    chkv("rstmid hit_count", 32'(hit_count), e_hit);
    idle();
    // PLRU bits of set 5 were cleared by the reset.
    do_miss("postrst", 3'd5, 1'b1, 1'b0, 4'b1111, 4'b0000, 0, 1'b0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
